// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline-register controller.
package pipe_pkg;

  localparam int PIPE_STAGES_DEFAULT = 5;

  typedef enum int {
    ST_IF_ID  = 0,
    ST_ID_EX  = 1,
    ST_EX_MEM = 2,
    ST_MEM_WB = 3,
    ST_WB     = 4
  } pipeStage_e;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [31:0] satInc(input logic [31:0] value, input int unsigned width);
    logic [31:0] maxVal;
    maxVal = 32'hFFFF_FFFF >> (32 - width);
    return (value == maxVal) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Upstream (fetch) and downstream (sink) handshake bundle of pipe_ctrl.
interface pipe_ctrl_if #(parameter int DATA_W = 32);

  logic              inValid;
  logic              inReady;
  logic [DATA_W-1:0] inData;
  logic              outValid;
  logic              outReady;
  logic [DATA_W-1:0] outData;

  modport master (output inValid, inData, outReady, input inReady, outValid, outData);
  modport slave  (input inValid, inData, outReady, output inReady, outValid, outData);

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline slot: a valid bit plus payload with load, kill and hold controls.
module pipe_stage_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic              i_validIn,
  input  logic              i_load,
  input  logic              i_kill,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Kill overrides any load so a flushed slot is empty next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (i_kill) begin
      r_valid <= 1'b0;
    end else if (i_enable) begin
      r_valid <= i_validIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_ctrl.sv
// Elastic chain of pipeline registers with back-pressure, stalls, masked flush
// and saturating performance counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int STAGES = PIPE_STAGES_DEFAULT,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pipe_ctrl_if.slave               bus,
  input  logic [STAGES-1:0]        i_stallReq,
  input  logic                     i_flush,
  input  logic [STAGES-1:0]        i_flushMask,
  output logic [STAGES-1:0]        o_stageValid,
  output logic [STAGES*DATA_W-1:0] o_stageData,
  output logic [STAGES-1:0]        o_stageAdv,
  input  logic                     i_cntClr,
  output logic [CNT_W-1:0]         o_stallCycles,
  output logic [CNT_W-1:0]         o_flushCount,
  output logic [CNT_W-1:0]         o_bubbleCount
);

  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_done;
  logic [STAGES-1:0] w_up;
  logic [STAGES-1:0] w_kill;
  logic [STAGES-1:0] w_killPrev;
  logic [STAGES:0]   w_ready;
  logic [DATA_W-1:0] w_data   [STAGES];
  logic [DATA_W-1:0] w_upData [STAGES];

  assign w_done     = w_valid & ~i_stallReq;
  assign w_kill     = {STAGES{i_flush}} & i_flushMask;
  assign w_up       = {w_done[STAGES-2:0], bus.inValid};
  assign w_killPrev = {w_kill[STAGES-2:0], 1'b0};

  // Ready ripples from the sink back to the head within the same cycle.
  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = bus.outReady;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_ready[i] = !w_valid[i] | (w_done[i] & w_ready[i+1]);
    end
  end

  assign w_upData[0] = bus.inData;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g > 0) begin : g_link
      assign w_upData[g] = w_data[g-1];
    end

    pipe_stage_reg #(.DATA_W(DATA_W)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_enable (w_ready[g]),
      .i_validIn(w_up[g] & ~w_killPrev[g]),
      .i_load   (w_ready[g] & w_up[g]),
      .i_kill   (w_kill[g]),
      .i_data   (w_upData[g]),
      .o_valid  (w_valid[g]),
      .o_data   (w_data[g])
    );

    assign o_stageData[g*DATA_W +: DATA_W] = w_data[g];
  end

  assign o_stageValid = w_valid;
  assign o_stageAdv   = w_ready[STAGES-1:0] & w_up & ~w_kill;
  assign bus.inReady  = w_ready[0];
  assign bus.outValid = w_valid[STAGES-1] & ~w_kill[STAGES-1];
  assign bus.outData  = w_data[STAGES-1];

  logic             r_seen;
  logic [CNT_W-1:0] r_stallCycles;
  logic [CNT_W-1:0] r_flushCount;
  logic [CNT_W-1:0] r_bubbleCount;
  logic             w_stallEv;
  logic             w_flushEv;
  logic             w_bubbleEv;

  // Bubbles only count once the pipe has held something, so the cold start is ignored.
  assign w_stallEv  = bus.inValid & ~w_ready[0];
  assign w_flushEv  = i_flush & (|i_flushMask);
  assign w_bubbleEv = bus.outReady & ~bus.outValid & (r_seen | (|w_valid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen        <= 1'b0;
      r_stallCycles <= '0;
      r_flushCount  <= '0;
      r_bubbleCount <= '0;
    end else begin
      if (|w_valid) begin
        r_seen <= 1'b1;
      end
      if (i_cntClr) begin
        r_stallCycles <= '0;
        r_flushCount  <= '0;
        r_bubbleCount <= '0;
      end else begin
        if (w_stallEv) begin
          r_stallCycles <= CNT_W'(satInc(32'(r_stallCycles), CNT_W));
        end
        if (w_flushEv) begin
          r_flushCount <= CNT_W'(satInc(32'(r_flushCount), CNT_W));
        end
        if (w_bubbleEv) begin
          r_bubbleCount <= CNT_W'(satInc(32'(r_bubbleCount), CNT_W));
        end
      end
    end
  end

  assign o_stallCycles = r_stallCycles;
  assign o_flushCount  = r_flushCount;
  assign o_bubbleCount = r_bubbleCount;

endmodule
